regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Two-requester register-file write port bundle.
// Requesters drive req/lock/addr/data and see grants plus the write port.
interface regfile_write_arbiter_if;
    logic        req0;
    logic        req1;
    logic        lock0;
    logic        lock1;
    logic [3:0]  addr0;
    logic [3:0]  addr1;
    logic [31:0] data0;
    logic [31:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic [3:0]  A3;
    logic        WE;
    logic [31:0] WD3;
    logic        busy;

    modport master (
        output req0, req1, lock0, lock1,
        output addr0, addr1, data0, data1,
        input  gnt0, gnt1, A3, WE, WD3, busy
    );

    modport slave (
        input  req0, req1, lock0, lock1,
        input  addr0, addr1, data0, data1,
        output gnt0, gnt1, A3, WE, WD3, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin register-file write arbiter with locked bursts.
// Define REGFILE_ARB_ZERO_GUARD_EN to write-protect register 0.
module regfile_write_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_e;

    localparam logic [3:0] MaxB = 4'(MAX_BURST);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [3:0]  a3_q;
    logic [31:0] wd3_q;
    logic        busy_q;

    logic        g0, g1;
    logic        xfer, gidx, glock, owner_req, we_d;
    logic [3:0]  gaddr, cnt_inc;
    logic [31:0] gdata;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (state_q == BURST) begin
                g0 = ~owner_q & bus.req0;
                g1 = owner_q & bus.req1;
            end else if (bus.req0 && bus.req1) begin
                // last_q==1 means requester 1 won last, so 0 wins now
                g0 = last_q;
                g1 = ~last_q;
            end else begin
                g0 = bus.req0;
                g1 = bus.req1;
            end
        end
    end

    assign xfer      = g0 | g1;
    assign gidx      = g1;
    assign glock     = gidx ? bus.lock1 : bus.lock0;
    assign gaddr     = gidx ? bus.addr1 : bus.addr0;
    assign gdata     = gidx ? bus.data1 : bus.data0;
    assign owner_req = owner_q ? bus.req1 : bus.req0;
    assign cnt_inc   = cnt_q + 4'd1;

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    assign we_d = xfer && (gaddr != 4'd0);
`else
    assign we_d = xfer;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (xfer) last_d = gidx;
        unique case (state_q)
            IDLE: begin
                if (xfer && glock && (MaxB > 4'd1)) begin
                    state_d = BURST;
                    owner_d = gidx;
                    cnt_d   = 4'd1;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if ((cnt_inc == MaxB) || !glock) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            a3_q    <= 4'd0;
            wd3_q   <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            busy_q  <= (state_d == BURST);
            if (xfer) begin
                a3_q  <= gaddr;
                wd3_q <= gdata;
            end
        end
    end

    assign bus.gnt0 = g0;
    assign bus.gnt1 = g1;
    assign bus.WE   = we_q;
    assign bus.A3   = a3_q;
    assign bus.WD3  = wd3_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter (MAX_BURST=4).
// Vectors run back to back; arbiter state carries between rows.
module tb_regfile_write_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    localparam logic ZeroWe = 1'b0;
`else
    localparam logic ZeroWe = 1'b1;
`endif

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, l0, l1;
        logic [3:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        eg0, eg1;
        logic        ewe;
        logic [3:0]  ea3;
        logic [31:0] ewd;
        logic        ebusy;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(
        input logic r0, r1, l0, l1,
        input logic [3:0] a0, a1,
        input logic [31:0] d0, d1,
        input logic eg0, eg1, ewe,
        input logic [3:0] ea3,
        input logic [31:0] ewd,
        input logic ebusy
    );
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe;
        v.ea3 = ea3; v.ewd = ewd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(
        input logic r0, r1, l0, l1,
        input logic [3:0] a0, a1,
        input logic [31:0] d0, d1
    );
        bus.req0 = r0; bus.req1 = r1;
        bus.lock0 = l0; bus.lock1 = l1;
        bus.addr0 = a0; bus.addr1 = a1;
        bus.data0 = d0; bus.data1 = d1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_gnt(input string name, input logic e0, input logic e1);
        #1;
        chk({name, " gnt"}, 64'({bus.gnt0, bus.gnt1}), 64'({e0, e1}));
    endtask

    task automatic chk_out(input string name, input logic ewe,
                           input logic [3:0] ea3, input logic [31:0] ewd,
                           input logic ebusy);
        if (ewe)
            chk({name, " out"}, 64'({bus.WE, bus.busy, bus.A3, bus.WD3}),
                64'({ewe, ebusy, ea3, ewd}));
        else
            chk({name, " out"}, 64'({bus.WE, bus.busy}), 64'({ewe, ebusy}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // alternation from reset, then sole requester
        tbl[0]  = mk(1,1,0,0, 2,7, 32'hA0,32'hB0, 1,0, 1, 2, 32'hA0, 0);
        tbl[1]  = mk(1,1,0,0, 2,7, 32'hA1,32'hB1, 0,1, 1, 7, 32'hB1, 0);
        tbl[2]  = mk(1,1,0,0, 4,8, 32'hA2,32'hB2, 1,0, 1, 4, 32'hA2, 0);
        tbl[3]  = mk(1,1,0,0, 4,8, 32'hA3,32'hB3, 0,1, 1, 8, 32'hB3, 0);
        tbl[4]  = mk(0,0,0,0, 0,0, 32'h0,32'h0, 0,0, 0, 0, 32'h0, 0);
        tbl[5]  = mk(1,0,0,0, 3,0, 32'hABCDE123,32'h0, 1,0, 1, 3, 32'hABCDE123, 0);
        // full 4-beat burst by requester 1 while 0 waits
        tbl[6]  = mk(0,1,0,1, 0,9, 32'h0,32'h11110000, 0,1, 1, 9, 32'h11110000, 1);
        tbl[7]  = mk(1,1,0,1, 6,9, 32'hC0,32'h11110001, 0,1, 1, 9, 32'h11110001, 1);
        tbl[8]  = mk(1,1,0,1, 6,9, 32'hC0,32'h11110002, 0,1, 1, 9, 32'h11110002, 1);
        tbl[9]  = mk(1,1,0,1, 6,9, 32'hC0,32'h11110003, 0,1, 1, 9, 32'h11110003, 0);
        tbl[10] = mk(1,1,0,1, 6,9, 32'hC0,32'hD0, 1,0, 1, 6, 32'hC0, 0);
        // owner drops req after 2 beats
        tbl[11] = mk(0,1,0,1, 0,10, 32'h0,32'hE0, 0,1, 1, 10, 32'hE0, 1);
        tbl[12] = mk(1,1,0,1, 6,10, 32'hC1,32'hE1, 0,1, 1, 10, 32'hE1, 1);
        tbl[13] = mk(1,0,0,0, 6,0, 32'hC2,32'h0, 0,0, 0, 0, 32'h0, 0);
        tbl[14] = mk(1,0,0,0, 6,0, 32'hC2,32'h0, 1,0, 1, 6, 32'hC2, 0);
        // owner ends burst by dropping lock
        tbl[15] = mk(0,1,0,1, 0,11, 32'h0,32'hF0, 0,1, 1, 11, 32'hF0, 1);
        tbl[16] = mk(1,1,0,0, 6,11, 32'hC3,32'hF1, 0,1, 1, 11, 32'hF1, 0);
        tbl[17] = mk(1,1,0,0, 12,13, 32'hC4,32'hF2, 1,0, 1, 12, 32'hC4, 0);
        tbl[18] = mk(1,0,0,0, 0,0, 32'h1,32'h0, 1,0, ZeroWe, 0, 32'h1, 0);

        rst = 1'b1;
        drive(1,1,0,0, 4'd1,4'd2, 32'h5,32'h6);
        tick();
        chk_gnt("rst", 0, 0);
        tick();
        chk("rst out", 64'({bus.WE, bus.busy, bus.A3, bus.WD3}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            chk_gnt($sformatf("v%0d", i), tbl[i].eg0, tbl[i].eg1);
            tick();
            chk_out($sformatf("v%0d", i), tbl[i].ewe, tbl[i].ea3,
                    tbl[i].ewd, tbl[i].ebusy);
        end

        // reset mid-burst aborts it and restores requester-0 priority
        drive(0,1,0,1, 0,5, 32'h0,32'h55);
        chk_gnt("mb start", 0, 1);
        tick();
        chk_out("mb start", 1, 5, 32'h55, 1);
        rst = 1'b1;
        drive(1,1,0,1, 7,5, 32'h77,32'h56);
        chk_gnt("mb rst", 0, 0);
        tick();
        chk_out("mb rst", 0, 0, 32'h0, 0);
        rst = 1'b0;
        drive(1,1,0,0, 7,5, 32'h77,32'h56);
        chk_gnt("mb after", 1, 0);
        tick();
        chk_out("mb after", 1, 7, 32'h77, 0);

        // reset in the cycle after a grant of addr 5
        drive(0,1,0,0, 0,5, 32'h0,32'h99);
        chk_gnt("pg grant", 0, 1);
        tick();
        chk_out("pg grant", 1, 5, 32'h99, 0);
        rst = 1'b1;
        drive(0,0,0,0, 0,0, 32'h0,32'h0);
        chk_gnt("pg rst", 0, 0);
        tick();
        chk("pg rst out", 64'({bus.WE, bus.busy, bus.A3}), 64'd0);
        rst = 1'b0;
        drive(1,1,0,0, 8,9, 32'h88,32'h98);
        chk_gnt("pg contest", 1, 0);
        tick();
        chk_out("pg contest", 1, 8, 32'h88, 0);

        drive(0,0,0,0, 0,0, 32'h0,32'h0);
        tick();
        chk_out("idle end", 0, 0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
